// File: rtl/wall_renderer.sv
// rtl/wall_renderer.sv - erase/redraw of a vertical wall band as a one-pixel-per-cycle VGA plot stream
// Optional macro WALL_GAP_EN punches a GAP_H-row background gap into the drawn wall at gap_y.
module wall_renderer #(
  parameter int WALL_WIDTH = 10,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int GAP_H      = 40
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] wall_x_old,
  input  logic [7:0] wall_x_new,
  input  logic [6:0] gap_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [2:0] COL_BG   = 3'b111;
  localparam logic [2:0] COL_WALL = 3'b100;

  state_t     state, state_nx;
  logic [7:0] old_r, old_nx;
  logic [7:0] new_r, new_nx;
  logic [6:0] gap_r, gap_nx;
  logic [7:0] dx, dx_nx;
  logic [6:0] dy, dy_nx;
  logic [7:0] x_nx;
  logic [6:0] y_nx;
  logic [2:0] col_nx;
  logic       plot_nx;
  logic       done_nx;
  logic [8:0] x_sum;
  logic       row_end;
  logic       pass_end;
  logic       in_gap;

`ifdef WALL_GAP_EN
  logic [7:0] gap_end;
  assign gap_end = {1'b0, gap_r} + 8'(GAP_H);
  assign in_gap  = (dy >= gap_r) && ({1'b0, dy} < gap_end);
`else
  logic unused_gap;
  assign unused_gap = (^gap_r) ^ (GAP_H != 0);
  assign in_gap     = 1'b0;
`endif

  // done is registered one cycle behind the DONE state, so busy covers it explicitly
  assign busy = (state != IDLE) || done;

  always_comb begin
    x_sum    = {1'b0, (state == DRAW) ? new_r : old_r} + {1'b0, dx};
    row_end  = (dx == 8'(WALL_WIDTH - 1));
    pass_end = row_end && (dy == 7'(SCREEN_H - 1));
    state_nx = state;
    old_nx   = old_r;
    new_nx   = new_r;
    gap_nx   = gap_r;
    dx_nx    = dx;
    dy_nx    = dy;
    x_nx     = x_out;
    y_nx     = y_out;
    col_nx   = colour_out;
    plot_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          old_nx   = wall_x_old;
          new_nx   = wall_x_new;
          gap_nx   = gap_y;
          dx_nx    = 8'd0;
          dy_nx    = 7'd0;
          state_nx = ERASE;
        end
      end
      ERASE, DRAW: begin
        x_nx    = x_sum[7:0];
        y_nx    = dy;
        // off-screen columns still burn their cycle so latency never depends on position
        plot_nx = (x_sum < 9'(SCREEN_W));
        col_nx  = ((state == ERASE) || in_gap) ? COL_BG : COL_WALL;
        if (row_end) begin
          dx_nx = 8'd0;
          dy_nx = dy + 7'd1;
        end else begin
          dx_nx = dx + 8'd1;
        end
        if (pass_end) begin
          dx_nx    = 8'd0;
          dy_nx    = 7'd0;
          state_nx = (state == ERASE) ? DRAW : DONE;
        end
      end
      DONE: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      old_r      <= 8'd0;
      new_r      <= 8'd0;
      gap_r      <= 7'd0;
      dx         <= 8'd0;
      dy         <= 7'd0;
      x_out      <= 8'd0;
      y_out      <= 7'd0;
      colour_out <= 3'd0;
      plot       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      old_r      <= old_nx;
      new_r      <= new_nx;
      gap_r      <= gap_nx;
      dx         <= dx_nx;
      dy         <= dy_nx;
      x_out      <= x_nx;
      y_out      <= y_nx;
      colour_out <= col_nx;
      plot       <= plot_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_wall_renderer.sv
// tb/tb_wall_renderer.sv - directed self-checking bench for wall_renderer at default parameters
module tb_wall_renderer;

  localparam int W = 10;
  localparam int H = 120;
  localparam int SW = 160;
  localparam int GH = 40;
  localparam int PASS_PX = W * H;
  localparam int DONE_CYC = 2 * PASS_PX + 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] wall_x_old;
  logic [7:0] wall_x_new;
  logic [6:0] gap_y;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot;

  int n_cmp = 0;
  int n_fail = 0;

  wall_renderer dut (
    .clk(clk), .resetn(resetn), .start(start),
    .wall_x_old(wall_x_old), .wall_x_new(wall_x_new), .gap_y(gap_y),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, plot, x_out, y_out, colour_out} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b plot=%b x=%0d y=%0d col=%b, need all 0",
               busy, done, plot, x_out, y_out, colour_out);
    end
  endtask

  task automatic run_redraw(input string name, input logic [7:0] o, input logic [7:0] n,
                            input logic [6:0] g, input int chg_at,
                            input int exp_erase, input int exp_draw);
    int bad = 0, ep = 0, dp = 0, done_cnt = 0, done_at = -1, k, idx;
    logic [8:0] ex;
    logic [6:0] ey;
    logic [2:0] ecol;
    logic eplot;
    wall_x_old = o; wall_x_new = n; gap_y = g; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_cycle0: busy=%b plot=%b, need busy=1 plot=0", name, busy, plot);
    end
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      if (c == chg_at) begin
        wall_x_old = ~o; wall_x_new = ~n; gap_y = ~g; start = 1'b1;
      end
      if (c == chg_at + 2) start = 1'b0;
      @(posedge clk); #1;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (c <= 2 * PASS_PX) begin
        k = c - 1;
        idx = k % PASS_PX;
        ex = {1'b0, (k < PASS_PX) ? o : n} + 9'(idx % W);
        ey = 7'(idx / W);
        eplot = (ex < 9'(SW));
        ecol = (k < PASS_PX) ? 3'b111 : 3'b100;
`ifdef WALL_GAP_EN
        if (k >= PASS_PX && int'(ey) >= int'(g) && int'(ey) < int'(g) + GH) ecol = 3'b111;
`endif
        if (plot !== eplot) bad++;
        else if (eplot && (x_out !== ex[7:0] || y_out !== ey || colour_out !== ecol)) bad++;
        if (busy !== 1'b1) bad++;
        if (plot === 1'b1) begin
          if (k < PASS_PX) ep++; else dp++;
        end
      end else if (plot !== 1'b0) begin
        bad++;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_stream: %0d bad pixel cycles, need 0", name, bad);
    end
    n_cmp++;
    if (ep != exp_erase) begin
      n_fail++;
      $display("FAIL %s_erase_plots: got %0d need %0d", name, ep, exp_erase);
    end
    n_cmp++;
    if (dp != exp_draw) begin
      n_fail++;
      $display("FAIL %s_draw_plots: got %0d need %0d", name, dp, exp_draw);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != DONE_CYC) begin
      n_fail++;
      $display("FAIL %s_done: got %0d pulses last at %0d, need 1 at %0d", name, done_cnt, done_at, DONE_CYC);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_busy: got %b need 0", name, busy);
    end
  endtask

  task automatic test_basic;
    run_redraw("basic", 8'd100, 8'd96, 7'd50, -10, 1200, 1200);
  endtask

  task automatic test_clip;
    run_redraw("clip", 8'd155, 8'd151, 7'd50, -10, 600, 1080);
  endtask

  task automatic test_same_position;
    run_redraw("same", 8'd50, 8'd50, 7'd0, -10, 1200, 1200);
  endtask

  task automatic test_input_change;
    run_redraw("change", 8'd100, 8'd96, 7'd50, 10, 1200, 1200);
  endtask

  task automatic test_back_to_back;
    int done_cnt = 0, done_at = -1, plots = 0, done_at2 = -1, plots2 = 0;
    wall_x_old = 8'd20; wall_x_new = 8'd30; gap_y = 7'd0; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= DONE_CYC + 1; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin done_cnt++; done_at = c; end
      if (plot === 1'b1) plots++;
    end
    n_cmp++;
    if (busy !== 1'b1 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: busy=%b plot=%b at cycle %0d, need busy=1 plot=0", busy, plot, DONE_CYC + 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (plot !== 1'b1 || x_out !== 8'd20 || y_out !== 7'd0 || colour_out !== 3'b111) begin
      n_fail++;
      $display("FAIL b2b_first_pixel: plot=%b x=%0d y=%0d col=%b, need 1 20 0 111", plot, x_out, y_out, colour_out);
    end
    if (plot === 1'b1) plots2++;
    for (int c = DONE_CYC + 3; c <= 2 * DONE_CYC + 4; c++) begin
      @(posedge clk); #1;
      if (plot === 1'b1) plots2++;
      if (done === 1'b1 && done_at2 < 0) done_at2 = c;
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != DONE_CYC) begin
      n_fail++;
      $display("FAIL b2b_done1: got %0d pulses last at %0d, need 1 at %0d", done_cnt, done_at, DONE_CYC);
    end
    n_cmp++;
    if (plots != 2 * PASS_PX) begin
      n_fail++;
      $display("FAIL b2b_plots1: got %0d need %0d", plots, 2 * PASS_PX);
    end
    n_cmp++;
    if (done_at2 != 2 * DONE_CYC + 1) begin
      n_fail++;
      $display("FAIL b2b_done2: got cycle %0d need %0d", done_at2, 2 * DONE_CYC + 1);
    end
    n_cmp++;
    if (plots2 != 2 * PASS_PX) begin
      n_fail++;
      $display("FAIL b2b_plots2: got %0d need %0d", plots2, 2 * PASS_PX);
    end
  endtask

  task automatic test_reset_mid;
    int stray = 0;
    wall_x_old = 8'd100; wall_x_new = 8'd96; gap_y = 7'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    n_cmp++;
    if (plot !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_active: plot=%b before reset, need 1", plot);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({plot, busy, done, x_out} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: plot=%b busy=%b done=%b x=%0d, need all 0", plot, busy, done, x_out);
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: %0d active cycles after release, need 0", stray);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0;
    wall_x_old = 8'd0; wall_x_new = 8'd0; gap_y = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    resetn = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_clip;
    test_same_position;
    test_input_change;
    test_back_to_back;
    test_reset_mid;
    test_basic;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
